// File: rtl/lc3b_types.sv
// Shared types for the LC-3b cache/memory integration: data word, 8-word line,
// and the state encoding of the Wishbone line store.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_8words;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_line_state_t;

endpackage

// File: rtl/wishbone.sv
// Wishbone bundle between the L1 memory-side master and the line store.
// Line-granular: ADR carries bits [15:4], data is one 128-bit line, SEL is per byte.
interface wishbone;
  import lc3b_types::*;

  logic        cyc;
  logic        stb;
  logic        we;
  lc3b_word    sel;
  logic [15:4] adr;
  lc3b_8words  dat_m;
  lc3b_8words  dat_s;
  logic        ack;
  logic        rty;

  modport slave  (input cyc, stb, we, sel, adr, dat_m, output dat_s, ack, rty);
  modport master (output cyc, stb, we, sel, adr, dat_m, input dat_s, ack, rty);

endinterface

// File: rtl/line_array.sv
// LINES x 128-bit line storage with a per-byte write mask and a registered
// read port. Contents are not touched by reset; only the read register is.
module line_array
  import lc3b_types::*;
#(
  parameter int LINES = 4096,
  parameter int IDXW  = $clog2(LINES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic [IDXW-1:0] idx,
  input  lc3b_word        mask,
  input  lc3b_8words      wdata,
  output lc3b_8words      rdata
);

  lc3b_8words mem [LINES];

  // Byte-masked line write: unselected bytes keep their old contents
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 16; i++) begin
        if (mask[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register: loads only on a read commit, otherwise holds the last line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/wb_line_memory.sv
// Wishbone slave line store: fixed programmable latency, RTY while pending,
// one-cycle ACK per completed transfer, and wrapping read/write transfer counters.
module wb_line_memory
  import lc3b_types::*;
#(
  parameter int LATENCY = 4,
  parameter int LINES   = 4096
) (
  input  logic     clk,
  input  logic     rst,
  wishbone.slave   wb,
  output lc3b_word read_count,
  output lc3b_word write_count
);

  localparam int       IDXW     = $clog2(LINES);
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);
  // With a latency of one the request is answered straight from IDLE
  localparam bit       DIRECT   = (LATENCY == 1);

  wb_line_state_t state;
  logic [7:0]     lat_cnt;
  logic [15:4]    adr_q;
  logic           we_q;
  lc3b_word       sel_q;
  lc3b_8words     dat_q;
  logic           ack_q;
  lc3b_8words     rdata;

  logic           req;
  logic           commit;
  logic [15:4]    arr_adr;
  logic           arr_we;
  lc3b_word       arr_sel;
  lc3b_8words     arr_dat;

  assign req    = wb.cyc & wb.stb;
  assign wb.ack = ack_q;
  assign wb.rty = req & ~ack_q;
  assign wb.dat_s = rdata;

  // Array access happens on the edge entering RESP; the direct path uses live inputs
  always_comb begin
    commit  = 1'b0;
    arr_adr = adr_q;
    arr_we  = we_q;
    arr_sel = sel_q;
    arr_dat = dat_q;
    if (rst) begin
      commit = 1'b0;
    end else if (DIRECT && (state == IDLE) && req) begin
      commit  = 1'b1;
      arr_adr = wb.adr;
      arr_we  = wb.we;
      arr_sel = wb.sel;
      arr_dat = wb.dat_m;
    end else if ((state == WAIT) && req && (lat_cnt == 8'd0)) begin
      commit = 1'b1;
    end else begin
      commit = 1'b0;
    end
  end

  line_array #(
    .LINES (LINES),
    .IDXW  (IDXW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .wr_en (commit & arr_we),
    .rd_en (commit & ~arr_we),
    .idx   (arr_adr[IDXW+3:4]),
    .mask  (arr_sel),
    .wdata (arr_dat),
    .rdata (rdata)
  );

  // Request FSM: accept and latch, count down the latency, one-cycle ACK, count on exit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lat_cnt     <= 8'd0;
      adr_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= 16'h0000;
      dat_q       <= '0;
      ack_q       <= 1'b0;
      read_count  <= 16'h0000;
      write_count <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          ack_q <= 1'b0;
          if (req) begin
            adr_q   <= wb.adr;
            we_q    <= wb.we;
            sel_q   <= wb.sel;
            dat_q   <= wb.dat_m;
            lat_cnt <= LAT_LOAD;
            if (DIRECT) begin
              state <= RESP;
              ack_q <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else if (lat_cnt == 8'd0) begin
            state <= RESP;
            ack_q <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end
        RESP: begin
          ack_q <= 1'b0;
          state <= IDLE;
          if (we_q) begin
            write_count <= write_count + 16'd1;
          end else begin
            read_count <= read_count + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_line_memory.sv
// Self-checking bench for wb_line_memory: table of line transfers on a LATENCY=4
// instance, hand sequences for abort and mid-transfer reset, and a LATENCY=1
// instance driven back-to-back through a full write-counter wrap.
module tb_wb_line_memory;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wishbone bus0 ();
  wishbone bus1 ();
  lc3b_word rc0, wc0, rc1, wc1;

  wb_line_memory #(.LATENCY(4), .LINES(4096)) dut0 (
    .clk(clk), .rst(rst), .wb(bus0), .read_count(rc0), .write_count(wc0)
  );

  wb_line_memory #(.LATENCY(1), .LINES(4096)) dut1 (
    .clk(clk), .rst(rst), .wb(bus1), .read_count(rc1), .write_count(wc1)
  );

  int checks = 0;
  int failures = 0;
  logic [127:0] sb_q [$];

  typedef struct {
    logic         we;
    logic [11:0]  adr;
    logic [15:0]  sel;
    logic [127:0] dat;
    logic [127:0] exp_dat;
    logic [15:0]  exp_rc;
    logic [15:0]  exp_wc;
  } vec_t;

  vec_t vecs [10];

  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] PA = {{7{16'hAAAA}}, 16'hBEEF};
  localparam logic [127:0] PM = 128'hFFEEDDCC_00000000_00000000_33221100;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transfer on dut0 (LATENCY=4); request inputs are scrambled during WAIT
  task automatic xfer(input string name, input logic we, input logic [11:0] adr,
                      input logic [15:0] sel, input logic [127:0] dat, input logic [127:0] exp_dat);
    int lat;
    int rty_n;
    logic [127:0] exp_q;
    bus0.cyc = 1'b1; bus0.stb = 1'b1; bus0.we = we;
    bus0.adr = adr; bus0.sel = sel; bus0.dat_m = dat;
    if (!we) sb_q.push_back(exp_dat);
    lat = 0;
    rty_n = 0;
    while (bus0.ack !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (bus0.ack !== 1'b1) begin
        if (bus0.rty === 1'b1) rty_n++;
        bus0.adr = ~adr; bus0.dat_m = ~dat; bus0.sel = ~sel; bus0.we = ~we;
      end
    end
    check({name, " latency"}, 128'(lat), 128'd5);
    check({name, " rty cycles"}, 128'(rty_n), 128'd4);
    check({name, " rty at ack"}, 128'(bus0.rty), 128'd0);
    if (!we) begin
      exp_q = sb_q.pop_front();
      check({name, " read data"}, bus0.dat_s, exp_q);
    end else begin
      check({name, " dat_s hold"}, bus0.dat_s, exp_dat);
    end
    bus0.cyc = 1'b0; bus0.stb = 1'b0;
    @(posedge clk); #1;
    check({name, " ack one cycle"}, 128'(bus0.ack), 128'd0);
  endtask

  initial begin
    int acks;
    int gap;
    int bad_gaps;
    int cyc_n;
    int first_lat;
    int wait_n;

    vecs[0] = '{1'b0, 12'h010, 16'h0000, 128'h0, 128'h0, 16'd1, 16'd0};
    vecs[1] = '{1'b1, 12'h010, 16'hFFFF, D1, 128'h0, 16'd1, 16'd1};
    vecs[2] = '{1'b0, 12'h010, 16'h0000, 128'h0, D1, 16'd2, 16'd1};
    vecs[3] = '{1'b1, 12'h020, 16'hFFFF, {8{16'hAAAA}}, D1, 16'd2, 16'd2};
    vecs[4] = '{1'b1, 12'h020, 16'h0003, {{7{16'h5555}}, 16'hBEEF}, D1, 16'd2, 16'd3};
    vecs[5] = '{1'b0, 12'h020, 16'h0000, 128'h0, PA, 16'd3, 16'd3};
    vecs[6] = '{1'b1, 12'h030, 16'hF00F, 128'hFFEEDDCC_BBAA9988_77665544_33221100, PA, 16'd3, 16'd4};
    vecs[7] = '{1'b0, 12'h030, 16'h0000, 128'h0, PM, 16'd4, 16'd4};
    vecs[8] = '{1'b0, 12'h040, 16'h0000, 128'h0, 128'h0, 16'd5, 16'd4};
    vecs[9] = '{1'b0, 12'h010, 16'h0000, 128'h0, D1, 16'd6, 16'd4};

    bus0.cyc = 1'b0; bus0.stb = 1'b0; bus0.we = 1'b0; bus0.sel = 16'h0; bus0.adr = 12'h0; bus0.dat_m = '0;
    bus1.cyc = 1'b0; bus1.stb = 1'b0; bus1.we = 1'b0; bus1.sel = 16'h0; bus1.adr = 12'h0; bus1.dat_m = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset ack", 128'(bus0.ack), 128'd0);
    check("reset dat_s", bus0.dat_s, 128'h0);
    check("reset read_count", 128'(rc0), 128'd0);
    check("reset write_count", 128'(wc0), 128'd0);
    check("reset rty", 128'(bus0.rty), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven transfers on the LATENCY=4 instance
    for (int i = 0; i < 10; i++) begin
      xfer($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].exp_dat);
      check($sformatf("vec%0d read_count", i), 128'(rc0), 128'(vecs[i].exp_rc));
      check($sformatf("vec%0d write_count", i), 128'(wc0), 128'(vecs[i].exp_wc));
    end

    // Abort: drop CYC in the second WAIT cycle of a write
    bus0.cyc = 1'b1; bus0.stb = 1'b1; bus0.we = 1'b1;
    bus0.adr = 12'h050; bus0.sel = 16'hFFFF; bus0.dat_m = D1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus0.cyc = 1'b0;
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus0.ack === 1'b1) acks++;
    end
    check("abort no ack", 128'(acks), 128'd0);
    check("abort write_count", 128'(wc0), 128'd4);
    check("abort read_count", 128'(rc0), 128'd6);
    bus0.stb = 1'b0;
    xfer("abort readback", 1'b0, 12'h050, 16'h0000, 128'h0, 128'h0);
    check("abort readback read_count", 128'(rc0), 128'd7);

    // Reset in the middle of a read's WAIT phase
    bus0.cyc = 1'b1; bus0.stb = 1'b1; bus0.we = 1'b0; bus0.adr = 12'h010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midreset ack", 128'(bus0.ack), 128'd0);
    check("midreset read_count", 128'(rc0), 128'd0);
    check("midreset write_count", 128'(wc0), 128'd0);
    check("midreset dat_s", bus0.dat_s, 128'h0);
    @(posedge clk); #1;
    check("midreset ack held", 128'(bus0.ack), 128'd0);
    bus0.cyc = 1'b0; bus0.stb = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    xfer("post-reset read", 1'b0, 12'h010, 16'h0000, 128'h0, D1);
    check("post-reset read_count", 128'(rc0), 128'd1);
    check("post-reset write_count", 128'(wc0), 128'd0);

    // LATENCY=1 instance: 65536 back-to-back writes with CYC held high
    acks = 0; gap = 0; bad_gaps = 0; cyc_n = 0; first_lat = 0;
    bus1.cyc = 1'b1; bus1.stb = 1'b1; bus1.we = 1'b1; bus1.sel = 16'hFFFF;
    bus1.adr = 12'h000; bus1.dat_m = 128'h0;
    while (acks < 65536 && cyc_n < 140000) begin
      @(posedge clk); #1;
      cyc_n++;
      if (bus1.ack === 1'b1) begin
        if (acks == 0) first_lat = cyc_n;
        else if (gap != 1) bad_gaps++;
        acks++;
        gap = 0;
        bus1.adr = 12'(acks);
        bus1.dat_m = 128'(acks);
      end else begin
        gap++;
      end
    end
    check("wrap ack total", 128'(acks), 128'd65536);
    check("wrap first latency", 128'(first_lat), 128'd1);
    check("wrap ack gaps", 128'(bad_gaps), 128'd0);
    check("wrap count before", 128'(wc1), 128'hFFFF);
    bus1.cyc = 1'b0; bus1.stb = 1'b0;
    @(posedge clk); #1;
    check("wrap write_count", 128'(wc1), 128'd0);
    check("wrap read_count", 128'(rc1), 128'd0);

    bus1.cyc = 1'b1; bus1.stb = 1'b1; bus1.we = 1'b0; bus1.adr = 12'h005;
    wait_n = 0;
    while (bus1.ack !== 1'b1 && wait_n < 10) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("lat1 read latency", 128'(wait_n), 128'd1);
    check("lat1 read data", bus1.dat_s, 128'd61445);
    bus1.cyc = 1'b0; bus1.stb = 1'b0;
    @(posedge clk); #1;
    check("lat1 read_count", 128'(rc1), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
